// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle accumulator core: opcodes, FSM states, flag bit positions.
package cpu_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned FLAGS_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OPC_W-1:0] OP_LDA  = 4'h2;
    localparam logic [OPC_W-1:0] OP_STA  = 4'h3;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h4;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h5;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h6;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h7;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h8;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h9;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hA;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'hB;
    localparam logic [OPC_W-1:0] OP_JN   = 4'hC;
    localparam logic [OPC_W-1:0] OP_JC   = 4'hD;
    localparam logic [OPC_W-1:0] OP_CMP  = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_DMEM,
        ST_HALT
    } state_t;

    // Opcodes that need a second memory access after decode.
    function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
        return op inside {OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result of ACC op operand plus the {Z,N,C,V} flags it would produce.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [OPC_W-1:0]   op,
    output logic [DATA_W-1:0]  result,
    output logic [FLAGS_W-1:0] flags
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            carry;
    logic            ovf;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the unsigned borrow (a < b).
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = b;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
                ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
                ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = b;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[DATA_W-1];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle accumulator CPU: FETCH/EXEC/DMEM sequencing over one req/ack memory port.
module mc_cpu_core
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [DATA_W-1:0]   acc_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [FLAGS_W-1:0]  flags_out,
    output logic                halted
);

    localparam int unsigned OPND_W = DATA_W - OPC_W;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [DATA_W-1:0]   ir, ir_nxt;
    logic [DATA_W-1:0]   acc, acc_nxt;
    logic [FLAGS_W-1:0]  flags, flags_nxt;
    logic                req_nxt, we_nxt, halted_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;

    logic [OPC_W-1:0]    opcode;
    logic [ADDR_W-1:0]   opnd_addr;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_res;
    logic [FLAGS_W-1:0]  alu_flags;
    logic [FLAGS_W-1:0]  flags_upd;
    logic                jump_taken;

    assign opcode    = ir[DATA_W-1 -: OPC_W];
    assign opnd_addr = ir[ADDR_W-1:0];
    assign imm       = {{OPC_W{ir[OPND_W-1]}}, ir[OPND_W-1:0]};
    assign alu_b     = (state == ST_DMEM) ? mem_rdata : imm;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (acc),
        .b      (alu_b),
        .op     (opcode),
        .result (alu_res),
        .flags  (alu_flags)
    );

    // Loads only touch Z/N; carry and overflow survive from the last arithmetic op.
    assign flags_upd = (opcode == OP_LDI || opcode == OP_LDA)
                     ? {alu_flags[FLAG_Z], alu_flags[FLAG_N], flags[FLAG_C], flags[FLAG_V]}
                     : alu_flags;

    always_comb begin
        jump_taken = 1'b0;
        case (opcode)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = flags[FLAG_Z];
            OP_JN:   jump_taken = flags[FLAG_N];
            OP_JC:   jump_taken = flags[FLAG_C];
            default: jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ir_nxt     = ir;
        acc_nxt    = acc;
        flags_nxt  = flags;
        halted_nxt = halted;
        req_nxt    = 1'b0;
        we_nxt     = 1'b0;
        addr_nxt   = mem_addr;
        wdata_nxt  = mem_wdata;

        case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_nxt    = mem_rdata;
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_mem_op(opcode)) begin
                    state_nxt = ST_DMEM;
                end else if (opcode == OP_HLT) begin
                    state_nxt  = ST_HALT;
                    halted_nxt = 1'b1;
                end else begin
                    state_nxt = ST_FETCH;
                    if (opcode == OP_LDI || opcode == OP_ADDI) begin
                        acc_nxt   = alu_res;
                        flags_nxt = flags_upd;
                    end
                    if (jump_taken) begin
                        pc_nxt = opnd_addr;
                    end
                end
            end
            ST_DMEM: begin
                if (mem_ack) begin
                    state_nxt = ST_FETCH;
                    if (opcode == OP_CMP) begin
                        flags_nxt = flags_upd;
                    end else if (opcode != OP_STA) begin
                        acc_nxt   = alu_res;
                        flags_nxt = flags_upd;
                    end
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase

        // Bus outputs are precomputed for the next state so they come straight from flops.
        req_nxt = (state_nxt == ST_FETCH) || (state_nxt == ST_DMEM);
        if (state_nxt == ST_FETCH) begin
            addr_nxt = pc_nxt;
        end else if (state_nxt == ST_DMEM) begin
            addr_nxt  = ir_nxt[ADDR_W-1:0];
            we_nxt    = (ir_nxt[DATA_W-1 -: OPC_W] == OP_STA);
            wdata_nxt = acc_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= '0;
            ir        <= '0;
            acc       <= '0;
            flags     <= '0;
            halted    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ir        <= ir_nxt;
            acc       <= acc_nxt;
            flags     <= flags_nxt;
            halted    <= halted_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

    assign acc_out   = acc;
    assign pc_out    = pc;
    assign flags_out = flags;

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: memory model with wait states and a scoreboard of expected accesses.
module tb_mc_cpu_core;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr, pc_out;
    logic [DW-1:0] mem_wdata, mem_rdata, acc_out;
    logic [3:0]    flags_out;
    logic          halted;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            cycles;
    } xact_t;

    xact_t         sb[$];
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            wait_cycles = 0;
    int            wait_cnt;
    logic          stall_en = 1'b0;
    logic [AW-1:0] stall_addr = '0;
    int            n_checks = 0;
    int            n_fail = 0;
    string         scen = "";
    int            hold = 0;
    logic          pend = 1'b0;
    logic [31:0]   snap = '0;

    mc_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .acc_out   (acc_out),
        .pc_out    (pc_out),
        .flags_out (flags_out),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    assign mem_ack   = mem_req && !(stall_en && mem_addr == stall_addr) && (wait_cnt >= wait_cycles);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk or posedge rst) begin
        if (rst)                      wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                          wait_cnt <= 0;
    end

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] opnd);
        return {op, opnd};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=0x%0h expected=0x%0h", scen, tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int cyc);
        xact_t e;
        e.we = we; e.addr = addr; e.wdata = wd; e.cycles = cyc;
        sb.push_back(e);
    endtask

    // One clock: sample on the falling edge, check bus stability, retire acked accesses.
    task automatic step();
        logic [31:0] cur;
        xact_t       e;
        @(negedge clk);
        cur = {4'b0, mem_req, mem_we, mem_addr, mem_wdata};
        if (rst) begin
            hold = 0;
            pend = 1'b0;
        end else begin
            if (pend) check("bus_held", cur, snap);
            pend = 1'b0;
            if (mem_req) begin
                hold++;
                if (mem_ack) begin
                    n_checks++;
                    assert (sb.size() != 0) else begin
                        n_fail++;
                        $error("FAIL %s/unexpected_access observed addr=0x%0h we=%0b expected=no access",
                               scen, mem_addr, mem_we);
                    end
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("acc_addr", 32'(mem_addr), 32'(e.addr));
                        check("acc_we", 32'(mem_we), 32'(e.we));
                        if (e.we) check("acc_wdata", 32'(mem_wdata), 32'(e.wdata));
                        check("acc_cycles", hold, e.cycles);
                    end
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    hold = 0;
                end else begin
                    pend = 1'b1;
                    snap = cur;
                end
            end
        end
    endtask

    task automatic start(input string name, input int waits);
        scen        = name;
        rst         = 1'b1;
        stall_en    = 1'b0;
        wait_cycles = waits;
        sb.delete();
        step();
        step();
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        check("req_in_reset", 32'(mem_req), 32'd0);
    endtask

    task automatic run_halt(input int budget, output int n);
        n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    int n;

    initial begin
        rst = 1'b1;

        // Reset state, LDI then HLT: only two fetches, no data access
        start("s1_ldi_hlt", 0);
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_flags", 32'(flags_out), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_bus", {mem_we, mem_addr, mem_wdata}, 32'd0);
        mem[0] = ins(4'h1, 12'h0FF);
        mem[1] = ins(4'hF, 12'h000);
        push(1'b0, 10'h000, '0, 1);
        push(1'b0, 10'h001, '0, 1);
        rst = 1'b0;
        run_halt(50, n);
        check("cycles_to_halt", n, 5);
        check("acc", 32'(acc_out), 32'h00FF);
        check("flags", 32'(flags_out), 32'h0);
        repeat (2) step();
        check("req_in_halt", 32'(mem_req), 32'd0);
        check("still_halted", 32'(halted), 32'd1);
        check("sb_drained", sb.size(), 0);

        // Signed overflow on ADD
        start("s2_add_ovf", 0);
        mem[0] = ins(4'h1, 12'h001);
        mem[1] = ins(4'h4, 12'h100);
        mem[2] = ins(4'hF, 12'h000);
        mem[10'h100] = 16'h7FFF;
        push(1'b0, 10'h000, '0, 1);
        push(1'b0, 10'h001, '0, 1);
        push(1'b0, 10'h100, '0, 1);
        push(1'b0, 10'h002, '0, 1);
        rst = 1'b0;
        run_halt(50, n);
        check("cycles_to_halt", n, 8);
        check("acc", 32'(acc_out), 32'h8000);
        check("flags", 32'(flags_out), 32'b0101);
        check("sb_drained", sb.size(), 0);

        // Borrow on SUB, then JC taken
        start("s3_sub_jc", 0);
        mem[0] = ins(4'h1, 12'h000);
        mem[1] = ins(4'h5, 12'h101);
        mem[2] = ins(4'hD, 12'h020);
        mem[10'h020] = ins(4'hF, 12'h000);
        mem[10'h101] = 16'h0001;
        push(1'b0, 10'h000, '0, 1);
        push(1'b0, 10'h001, '0, 1);
        push(1'b0, 10'h101, '0, 1);
        push(1'b0, 10'h002, '0, 1);
        push(1'b0, 10'h020, '0, 1);
        rst = 1'b0;
        run_halt(50, n);
        check("acc", 32'(acc_out), 32'hFFFF);
        check("flags", 32'(flags_out), 32'b0110);
        check("pc", 32'(pc_out), 32'h021);
        check("sb_drained", sb.size(), 0);

        // STA with three wait states on every access
        start("s4_sta_wait", 3);
        mem[0] = ins(4'h2, 12'h102);
        mem[1] = ins(4'h3, 12'h200);
        mem[2] = ins(4'hF, 12'h000);
        mem[10'h102] = 16'hA5A5;
        push(1'b0, 10'h000, '0, 4);
        push(1'b0, 10'h102, '0, 4);
        push(1'b0, 10'h001, '0, 4);
        push(1'b1, 10'h200, 16'hA5A5, 4);
        push(1'b0, 10'h002, '0, 4);
        rst = 1'b0;
        run_halt(100, n);
        check("cycles_to_halt", n, 24);
        check("mem_stored", 32'(mem[10'h200]), 32'hA5A5);
        check("acc", 32'(acc_out), 32'hA5A5);
        check("flags", 32'(flags_out), 32'b0100);
        check("sb_drained", sb.size(), 0);

        // PC wrap from 0x3FF to 0x000, then CMP with equal operand
        start("s5_wrap_cmp", 0);
        mem[0] = ins(4'hB, 12'h010);
        mem[1] = ins(4'h1, 12'h000);
        mem[2] = ins(4'hA, 12'h3FF);
        mem[10'h3FF] = ins(4'h0, 12'h000);
        mem[10'h010] = ins(4'h1, 12'h123);
        mem[10'h011] = ins(4'hE, 12'h103);
        mem[10'h012] = ins(4'hF, 12'h000);
        mem[10'h103] = 16'h0123;
        push(1'b0, 10'h000, '0, 1);
        push(1'b0, 10'h001, '0, 1);
        push(1'b0, 10'h002, '0, 1);
        push(1'b0, 10'h3FF, '0, 1);
        push(1'b0, 10'h000, '0, 1);
        push(1'b0, 10'h010, '0, 1);
        push(1'b0, 10'h011, '0, 1);
        push(1'b0, 10'h103, '0, 1);
        push(1'b0, 10'h012, '0, 1);
        rst = 1'b0;
        run_halt(100, n);
        check("acc", 32'(acc_out), 32'h0123);
        check("flags", 32'(flags_out), 32'b1000);
        check("pc", 32'(pc_out), 32'h013);
        check("sb_drained", sb.size(), 0);

        // Asynchronous reset while DMEM waits on a withheld ack
        start("s6_async_rst", 0);
        mem[0] = ins(4'h1, 12'h055);
        mem[1] = ins(4'h2, 12'h104);
        mem[2] = ins(4'hF, 12'h000);
        mem[10'h104] = 16'h8001;
        stall_addr = 10'h104;
        stall_en   = 1'b1;
        push(1'b0, 10'h000, '0, 1);
        push(1'b0, 10'h001, '0, 1);
        rst = 1'b0;
        n = 0;
        while (!(mem_req && mem_addr == 10'h104) && n < 20) begin
            step();
            n++;
        end
        check("reach_dmem", 32'(mem_req && mem_addr == 10'h104), 32'd1);
        check("pre_acc", 32'(acc_out), 32'h0055);
        check("pre_pc", 32'(pc_out), 32'h002);
        #2 rst = 1'b1;
        #1;
        check("req_async_drop", 32'(mem_req), 32'd0);
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_flags_halt", {flags_out, halted}, 32'd0);
        check("rst_bus", {mem_we, mem_addr, mem_wdata}, 32'd0);
        check("sb_before_restart", sb.size(), 0);
        step();
        step();
        stall_en = 1'b0;
        sb.delete();
        push(1'b0, 10'h000, '0, 1);
        push(1'b0, 10'h001, '0, 1);
        push(1'b0, 10'h104, '0, 1);
        push(1'b0, 10'h002, '0, 1);
        rst = 1'b0;
        step();
        check("first_fetch", {mem_req, mem_we, mem_addr}, {20'd0, 1'b1, 1'b0, 10'h000});
        run_halt(50, n);
        check("cycles_to_halt", n, 7);
        check("acc", 32'(acc_out), 32'h8001);
        check("flags", 32'(flags_out), 32'b0100);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
